// File: rtl/drw_rectseq.sv
`default_nettype none
// ============================================================================
// Module      : drw_rectseq
// Description : Rectangle line sequencer. Splits one PATBLT/BITBLT rectangle
//               command into per-line requests for drw_vramctrl, stepping
//               the destination and source addresses by their strides.
// Revision    : 1.0 - initial release
// ============================================================================
module drw_rectseq #(
    parameter int PIX_BYTES = 4
) (
    input  logic        CLK,
    input  logic        ARST,
    input  logic        CMD_START,
    input  logic        CMD_MODE,
    input  logic        CMD_BLEND,
    input  logic        CMD_ABORT,
    input  logic [31:0] DST_BASE,
    input  logic [31:0] SRC_BASE,
    input  logic [15:0] DST_STRIDE,
    input  logic [15:0] SRC_STRIDE,
    input  logic [10:0] RECT_W,
    input  logic [10:0] RECT_H,
    output logic        CMD_BUSY,
    output logic        CMD_DONE,
    output logic        CMD_ABORTED,
    output logic        LINE_START,
    input  logic        LINE_BUSY,
    output logic [31:0] LINE_ADDR_DST,
    output logic [31:0] LINE_ADDR_SRC,
    output logic [10:0] LINE_LEN,
    output logic        LINE_CMD_MODE,
    output logic        LINE_BLEND,
    output logic [10:0] LINE_IDX
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_ACK   = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [10:0] r_h;
    logic [15:0] r_dst_stride;
    logic [15:0] r_src_stride;
    logic        r_aborted;

    logic [15:0] w_line_bytes;
    logic        w_zero;
    logic        w_accept;
    logic        w_last;
    logic        w_line_end;
    logic        w_finish;
    logic        w_advance;

    // A line of zero bytes (zero width) or zero lines means nothing to draw.
    assign w_line_bytes = 16'(RECT_W) * 16'(PIX_BYTES);
    assign w_zero       = (w_line_bytes == 16'd0) || (RECT_H == 11'd0);

    assign w_accept   = (r_state == S_IDLE) && CMD_START;
    assign w_last     = (LINE_IDX == (r_h - 11'd1));
    assign w_line_end = (r_state == S_RUN) && !LINE_BUSY;
    assign w_finish   = w_line_end && (w_last || CMD_ABORT);
    assign w_advance  = w_line_end && !w_last && !CMD_ABORT;

    // State register.
    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort is only looked at once the issued line ends.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (CMD_START) begin
                    w_state_nxt = w_zero ? S_DONE : S_START;
                end
            end
            S_START: w_state_nxt = S_ACK;
            S_ACK: begin
                if (LINE_BUSY) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!LINE_BUSY) begin
                    w_state_nxt = (w_last || CMD_ABORT) ? S_DONE : S_START;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Command latch and per-line address stepping; LINE_* only move on
    // acceptance or between lines, never while a line is in flight.
    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            r_h           <= '0;
            r_dst_stride  <= '0;
            r_src_stride  <= '0;
            r_aborted     <= 1'b0;
            LINE_ADDR_DST <= '0;
            LINE_ADDR_SRC <= '0;
            LINE_LEN      <= '0;
            LINE_CMD_MODE <= 1'b0;
            LINE_BLEND    <= 1'b0;
            LINE_IDX      <= '0;
        end else if (w_accept) begin
            r_h           <= RECT_H;
            r_dst_stride  <= DST_STRIDE;
            r_src_stride  <= SRC_STRIDE;
            r_aborted     <= 1'b0;
            LINE_LEN      <= RECT_W;
            LINE_CMD_MODE <= CMD_MODE;
            LINE_BLEND    <= CMD_BLEND;
            if (!w_zero) begin
                LINE_ADDR_DST <= DST_BASE;
                LINE_ADDR_SRC <= SRC_BASE;
                LINE_IDX      <= '0;
            end
        end else if (w_advance) begin
            LINE_ADDR_DST <= LINE_ADDR_DST + {16'b0, r_dst_stride};
            if (LINE_CMD_MODE) begin
                LINE_ADDR_SRC <= LINE_ADDR_SRC + {16'b0, r_src_stride};
            end
            LINE_IDX <= LINE_IDX + 11'd1;
        end else if (w_finish) begin
            // Finishing on the last line is a normal end even if abort is up.
            r_aborted <= CMD_ABORT && !w_last;
        end
    end

    assign CMD_BUSY    = (r_state == S_START) || (r_state == S_ACK) || (r_state == S_RUN);
    assign CMD_DONE    = (r_state == S_DONE);
    assign CMD_ABORTED = (r_state == S_DONE) && r_aborted;
    assign LINE_START  = (r_state == S_START);

endmodule
`default_nettype wire
